line_rev_sched: RTL

LINE_REV_SCHED -- requirements
Module: line_rev_sched

---
 rtl/line_rev_sched.sv | 134 +++++++++++++
 1 files changed

// File: rtl/line_rev_sched.sv
// Line reverser: ping-pongs two external SRAM line banks so that each line is written
// in forward order while the previous line is read back in reverse order.
module line_rev_sched #(
    parameter int unsigned DWIDTH = 22,
    parameter int unsigned AWIDTH = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clken,
    input  logic [10:0]       width,
    input  logic [10:0]       height,
    input  logic              frame_start,
    input  logic              din_valid,
    input  logic [DWIDTH-1:0] din,
    output logic              in_ready,
    output logic              dout_valid,
    output logic [DWIDTH-1:0] dout,
    output logic [1:0]        wr_en_n,
    output logic [AWIDTH-1:0] wr_addr,
    output logic [AWIDTH-1:0] rd_addr,
    output logic [DWIDTH-1:0] sram_din,
    input  logic [DWIDTH-1:0] q0,
    input  logic [DWIDTH-1:0] q1,
    output logic              busy,
    output logic              frame_done
);

    localparam int unsigned CW = AWIDTH + 1;

    typedef enum logic [1:0] {StIdle, StFill, StStream, StDrain} state_e;

    state_e            state;
    logic              wbank, rd_bank, dv_q, done_q;
    logic [CW-1:0]     wcnt, rcnt, width_r;
    logic [10:0]       height_r, lines;
    logic [AWIDTH-1:0] wr_addr_q, rd_addr_q;
    logic              rd_pending, accept, rd_issue, w_done, r_done, last_line;

    assign in_ready   = ((state == StFill) || (state == StStream)) && (wcnt < width_r);
    assign rd_pending = ((state == StStream) || (state == StDrain)) && (rcnt < width_r);
    assign accept     = clken & din_valid & in_ready;
    assign rd_issue   = clken & rd_pending;

    // Line-complete flags look one accept/issue ahead so the swap lands on the same edge
    // as the final word of the line, keeping the output stream gapless.
    assign w_done    = (wcnt == width_r) || (accept && ((wcnt + CW'(1)) == width_r));
    assign r_done    = (rcnt == width_r) || (rd_issue && ((rcnt + CW'(1)) == width_r));
    assign last_line = ((lines + 11'd1) == height_r);

    // Addresses follow the counters while active and otherwise hold the last used value,
    // so a stalled read keeps the SRAM presenting the word still owed on dout.
    assign wr_addr  = accept ? AWIDTH'(wcnt) : wr_addr_q;
    assign rd_addr  = rd_issue ? AWIDTH'(width_r - rcnt - CW'(1)) : rd_addr_q;
    assign wr_en_n  = accept ? (wbank ? 2'b01 : 2'b10) : 2'b11;
    assign sram_din = din;

    assign dout       = rd_bank ? q1 : q0;
    assign dout_valid = dv_q & clken;
    assign busy       = (state != StIdle);
    assign frame_done = done_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= StIdle;
            wbank     <= 1'b0;
            rd_bank   <= 1'b0;
            dv_q      <= 1'b0;
            done_q    <= 1'b0;
            wcnt      <= '0;
            rcnt      <= '0;
            width_r   <= '0;
            height_r  <= '0;
            lines     <= '0;
            wr_addr_q <= '0;
            rd_addr_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (clken) begin
                dv_q <= rd_issue;
                if (accept) begin
                    wcnt      <= wcnt + CW'(1);
                    wr_addr_q <= wr_addr;
                end
                if (rd_issue) begin
                    rcnt      <= rcnt + CW'(1);
                    rd_addr_q <= rd_addr;
                    rd_bank   <= ~wbank;
                end
                case (state)
                    StIdle: begin
                        if (frame_start && (width != '0) && (height != '0)) begin
                            state    <= StFill;
                            wbank    <= 1'b0;
                            wcnt     <= '0;
                            rcnt     <= '0;
                            lines    <= '0;
                            width_r  <= CW'(width);
                            height_r <= height;
                        end
                    end
                    StFill: begin
                        if (w_done) begin
                            wbank <= ~wbank;
                            wcnt  <= '0;
                            rcnt  <= '0;
                            lines <= 11'd1;
                            state <= (height_r > 11'd1) ? StStream : StDrain;
                        end
                    end
                    StStream: begin
                        if (w_done && r_done) begin
                            wbank <= ~wbank;
                            wcnt  <= '0;
                            rcnt  <= '0;
                            lines <= lines + 11'd1;
                            if (last_line) begin
                                state <= StDrain;
                            end
                        end
                    end
                    StDrain: begin
                        // The final word is on dout this cycle; finish on this edge.
                        if (rcnt == width_r) begin
                            state  <= StIdle;
                            done_q <= 1'b1;
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule
